// File: rtl/instruction_control_unit.sv
// Four-phase sequencer and instruction decoder for the 8-bit CPU, with memory
// wait-state handshaking, conditional-jump resolution, halt and stall-timeout fault.
module instruction_control_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  input_clear_n,
  input  logic                  input_clock_enable,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  flag_zero,
  input  logic                  flag_carry,
  output logic                  fetch,
  output logic                  decode,
  output logic                  execute,
  output logic                  increment,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-5:0] operand,
  output logic                  op_move,
  output logic                  op_add,
  output logic                  op_sub,
  output logic                  op_and,
  output logic                  op_load,
  output logic                  op_store,
  output logic                  op_jump,
  output logic                  op_jumpz,
  output logic                  op_jumpnz,
  output logic                  op_jumpc,
  output logic                  op_jumpnc,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  halted,
  output logic                  fault
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, INCREMENT, HALTED, FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic                  jump_taken_q, jump_taken_d;

  logic [3:0] opcode;
  logic is_move, is_add, is_sub, is_and, is_load, is_store;
  logic is_jump, is_jumpz, is_jumpnz, is_jumpc, is_jumpnc, is_halt;
  logic legal, is_mem, waiting, timeout_hit, taken_now;

  assign opcode = ir_q[DATA_WIDTH-1:DATA_WIDTH-4];

  always_comb begin
    is_move   = 1'b0;
    is_add    = 1'b0;
    is_sub    = 1'b0;
    is_and    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_jump   = 1'b0;
    is_jumpz  = 1'b0;
    is_jumpnz = 1'b0;
    is_jumpc  = 1'b0;
    is_jumpnc = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      4'h0:    is_move   = 1'b1;
      4'h1:    is_add    = 1'b1;
      4'h2:    is_sub    = 1'b1;
      4'h3:    is_and    = 1'b1;
      4'h4:    is_load   = 1'b1;
      4'h5:    is_store  = 1'b1;
      4'h8:    is_jump   = 1'b1;
      4'h9:    is_jumpz  = 1'b1;
      4'hA:    is_jumpnz = 1'b1;
      4'hB:    is_jumpc  = 1'b1;
      4'hC:    is_jumpnc = 1'b1;
      4'hF:    is_halt   = 1'b1;
      default: ;
    endcase
  end

  assign legal = is_move | is_add | is_sub | is_and | is_load | is_store |
                 is_jump | is_jumpz | is_jumpnz | is_jumpc | is_jumpnc | is_halt;
  assign is_mem = is_load | is_store;

  // The stall counter only runs while a memory access is outstanding.
  assign waiting     = (state_q == FETCH) || ((state_q == EXECUTE) && is_mem);
  assign timeout_hit = waiting && !mem_ready && (wait_q == CW'(TIMEOUT - 1));

  assign taken_now = is_jump | (is_jumpz & flag_zero) | (is_jumpnz & !flag_zero) |
                     (is_jumpc & flag_carry) | (is_jumpnc & !flag_carry);

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    wait_d       = wait_q;
    jump_taken_d = jump_taken_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
          ir_d    = mem_rdata;
        end else if (timeout_hit) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXECUTE;
          wait_d  = '0;
        end else begin
          state_d = FAULT;
        end
      end
      EXECUTE: begin
        jump_taken_d = taken_now;
        if (is_halt) begin
          state_d = HALTED;
        end else if (is_mem) begin
          if (mem_ready) begin
            state_d = INCREMENT;
          end else if (timeout_hit) begin
            state_d = FAULT;
          end else begin
            wait_d = wait_q + CW'(1);
          end
        end else begin
          state_d = INCREMENT;
        end
      end
      INCREMENT: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge input_clear_n) begin
    if (!input_clear_n) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      wait_q       <= '0;
      jump_taken_q <= 1'b0;
    end else if (input_clock_enable) begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      wait_q       <= wait_d;
      jump_taken_q <= jump_taken_d;
    end
  end

  assign fetch     = (state_q == FETCH);
  assign decode    = (state_q == DECODE);
  assign execute   = (state_q == EXECUTE);
  assign increment = (state_q == INCREMENT);
  assign halted    = (state_q == HALTED);
  assign fault     = (state_q == FAULT);

  assign ir      = ir_q;
  assign operand = ir_q[DATA_WIDTH-5:0];

  assign op_move   = execute & is_move;
  assign op_add    = execute & is_add;
  assign op_sub    = execute & is_sub;
  assign op_and    = execute & is_and;
  assign op_load   = execute & is_load;
  assign op_store  = execute & is_store;
  assign op_jump   = execute & is_jump;
  assign op_jumpz  = execute & is_jumpz;
  assign op_jumpnz = execute & is_jumpnz;
  assign op_jumpc  = execute & is_jumpc;
  assign op_jumpnc = execute & is_jumpnc;

  assign mem_read  = fetch | (execute & is_load);
  assign mem_write = execute & is_store;

  assign pc_load = increment & jump_taken_q;
  assign pc_inc  = increment & !jump_taken_q;

endmodule

// File: doc/instruction_control_unit.md
# instruction_control_unit

Parametrised control unit for the 8-bit CPU that merges the four-phase sequence generator and the complete instruction decoder into one block. It adds wait-state handshaking to memory, a registered instruction register, conditional-jump resolution from ALU flags, a halt state and a stall-timeout fault. It sits between program memory / the register file and the datapath, driving phase strobes, decoded operation strobes and program-counter control.

## Interface
- DATA_WIDTH, 8, instruction width; opcode is ir[DATA_WIDTH-1:DATA_WIDTH-4], operand is ir[DATA_WIDTH-5:0]; legal values are 8 and above.
- TIMEOUT, 16, consecutive enabled wait cycles with mem_ready low before a fault; legal values are 2 and above.
- clock  input  1  system clock; all state changes on the rising edge.
- input_clear_n  input  1  asynchronous active-low reset.
- input_clock_enable  input  1  when low, all state, counter and registers hold.
- mem_rdata  input  DATA_WIDTH  instruction word from program memory.
- mem_ready  input  1  memory completes the current access this cycle.
- flag_zero, flag_carry  input  1 each  ALU flags, sampled in EXECUTE.
- fetch, decode, execute, increment  output  1 each  one-hot phase strobes.
- mem_read  output  1  high in FETCH, and in EXECUTE of LOAD.
- mem_write  output  1  high in EXECUTE of STORE.
- ir  output  DATA_WIDTH  registered instruction.
- operand  output  DATA_WIDTH-4  ir[DATA_WIDTH-5:0].
- op_move, op_add, op_sub, op_and, op_load, op_store, op_jump, op_jumpz, op_jumpnz, op_jumpc, op_jumpnc  output  1 each  decoded strobes, high only while execute=1.
- pc_inc, pc_load  output  1 each  PC control, mutually exclusive, high only in INCREMENT.
- halted, fault  output  1 each  sticky status.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, INCREMENT, HALTED, FAULT. The phase strobes decode the state directly; all are 0 in IDLE, HALTED and FAULT.
- Opcode map:
  - 0000 MOVE, 0001 ADD, 0010 SUB, 0011 AND, 0100 LOAD, 0101 STORE
  - 1000 JUMP, 1001 JUMPZ, 1010 JUMPNZ, 1011 JUMPC, 1100 JUMPNC, 1111 HALT
  - All other opcodes are illegal.
- Transitions apply only on enabled edges (input_clock_enable=1):
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE when mem_ready=1; on that edge ir<=mem_rdata. Otherwise stay in FETCH.
  - DECODE→EXECUTE for legal opcodes; DECODE→FAULT for illegal opcodes.
  - EXECUTE:
    - LOAD/STORE advance to INCREMENT only when mem_ready=1.
    - HALT goes to HALTED.
    - All other opcodes go to INCREMENT after 1 cycle.
  - INCREMENT→FETCH.
  - HALTED and FAULT are terminal until reset.
- Jump resolution on the EXECUTE exit edge: register jump_taken = JUMP, or JUMPZ&zero, or JUMPNZ&!zero, or JUMPC&carry, or JUMPNC&!carry.
- In INCREMENT: pc_load=jump_taken and pc_inc=!jump_taken.
- Wait counter: clears on entry to FETCH and EXECUTE. It increments on each enabled cycle in FETCH, or in EXECUTE of LOAD/STORE, while mem_ready=0. When the count reaches TIMEOUT-1 with mem_ready still 0, the next state is FAULT. mem_ready=1 on that same edge wins, and the transition is normal.
- halted=1 in HALTED. fault=1 in FAULT. Neither state can be left without reset.

## Timing
- Reset (asynchronous, immediate) puts the block in IDLE:
  - ir=0, wait counter=0, jump_taken=0.
  - All outputs 0 except operand=0.
- Reset asserted mid-instruction aborts the instruction with no further memory strobes.
- Zero-wait instruction (mem_ready always 1): 4 cycles, FETCH, DECODE, EXECUTE, INCREMENT. The first FETCH is on the cycle after the first enabled edge after reset release.
- Each cycle mem_ready is low in a wait state adds one cycle.
- Decoded strobes and mem_write are combinational from state and ir. They are valid the whole EXECUTE cycle, glitch-free relative to the state register.
- With input_clock_enable=0, outputs hold their current values and mem_read/mem_write remain asserted if they already were. The timeout counter does not advance.
- Flags are sampled only on the EXECUTE exit edge; flag changes elsewhere have no effect.

## Test plan
- Reset, then ADD 0x1_5 (mem_rdata=8'h15), mem_ready=1 -> fetch, decode, execute, increment on consecutive cycles; op_add=1 in EXECUTE with operand=4'h5; pc_inc=1 in INCREMENT; next cycle fetch=1.
- LOAD 8'h43 with mem_ready low for 3 EXECUTE cycles -> op_load and mem_read held 4 cycles; then INCREMENT with pc_inc=1.
- JUMPZ 8'h9A with flag_zero=1 -> pc_load=1, pc_inc=0. Repeat with flag_zero=0 -> pc_inc=1. JUMPNC 8'hC0 with carry=0 -> pc_load=1.
- Illegal opcode 8'h70 -> after DECODE, state FAULT: fault=1, all phase strobes 0, stays there until input_clear_n=0.
- mem_ready held 0 in FETCH for TIMEOUT=16 cycles -> fault=1 on the 16th edge. Separately, mem_ready=1 exactly on the 16th cycle -> normal DECODE, no fault.
- HALT 8'hF0 -> halted=1 after EXECUTE, no further fetch. Toggle input_clock_enable=0 mid-EXECUTE of STORE -> state and mem_write frozen. Async reset mid-FETCH -> all outputs 0 immediately.
